// File: rtl/tile_map_ram_pkg.sv
// Shared definitions for the battle-tank tile map: tile codes, loader
// state encoding and loader mode constants.
package tile_map_pkg;

    localparam logic [2:0] TILE_EMPTY     = 3'd0;
    localparam logic [2:0] TILE_BRICK     = 3'd1;
    localparam logic [2:0] TILE_STEEL     = 3'd2;
    localparam logic [2:0] TILE_WATER     = 3'd3;
    localparam logic [2:0] TILE_TREE      = 3'd4;
    localparam logic [2:0] TILE_BASE      = 3'd5;
    localparam logic [2:0] TILE_BASE_DEAD = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COPY_PRIME,
        ST_COPY,
        ST_FINISH
    } load_state_e;

    localparam logic LOAD_CLEAR = 1'b0;
    localparam logic LOAD_COPY  = 1'b1;

endpackage

// File: rtl/tile_map_ram_if.sv
// Bus bundle of the tile map: game-logic write port, renderer/collision
// read ports, loader control and the level-ROM handshake.
interface tile_map_ram_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RD     = 2
);
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           wr_ack;
    logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0]   rd_data;
    logic                           load_start;
    logic                           load_mode;
    logic [ADDR_WIDTH-1:0]          rom_addr;
    logic [DATA_WIDTH-1:0]          rom_data;
    logic                           busy;
    logic                           done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, load_start, load_mode, rom_data,
        input  wr_ack, rd_data, rom_addr, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, load_start, load_mode, rom_data,
        output wr_ack, rd_data, rom_addr, busy, done
    );
endinterface

// File: rtl/tile_map_loader.sv
// Level loader: clears the map to a fill code or copies a level image from a
// ROM with one cycle of registered latency, one cell per clock.
module tile_map_loader
    import tile_map_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 192,
    parameter int FILL_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_mode,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  lw_en,
    output logic [ADDR_WIDTH-1:0] lw_addr,
    output logic [DATA_WIDTH-1:0] lw_data
);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is reachable without wrapping.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      LAST_C  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      ONE_C   = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] FILL_C  = DATA_WIDTH'(FILL_VALUE);

    load_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        lw_en      = 1'b0;
        lw_addr    = '0;
        lw_data    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    cnt_d = '0;
                    if (load_mode == LOAD_COPY) begin
                        state_d    = ST_COPY_PRIME;
                        rom_addr_d = '0;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                lw_en   = 1'b1;
                lw_addr = ADDR_WIDTH'(cnt_q);
                lw_data = FILL_C;
                cnt_d   = cnt_q + ONE_C;
                if (cnt_q == LAST_C) state_d = ST_FINISH;
            end
            ST_COPY_PRIME: begin
                cnt_d   = ONE_C;
                state_d = ST_COPY;
                if (cnt_d < DEPTH_C) rom_addr_d = ADDR_WIDTH'(cnt_d);
            end
            ST_COPY: begin
                // ROM data arriving now belongs to the address issued last cycle.
                lw_en   = 1'b1;
                lw_addr = ADDR_WIDTH'(cnt_q - ONE_C);
                lw_data = rom_data;
                if (cnt_q == DEPTH_C) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                    if (cnt_d < DEPTH_C) rom_addr_d = ADDR_WIDTH'(cnt_d);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign rom_addr = rom_addr_q;
    assign busy     = (state_q == ST_CLEAR) || (state_q == ST_COPY_PRIME) || (state_q == ST_COPY);
    assign done     = (state_q == ST_FINISH);

endmodule

// File: rtl/tile_map_ram.sv
// Tile-map store: one write port for game logic, NUM_RD registered read
// ports, and a built-in loader that owns the write path while busy.
module tile_map_ram
    import tile_map_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 192,
    parameter int NUM_RD     = 2,
    parameter int FILL_VALUE = 0
) (
    input  logic          clk,
    input  logic          rst,
    tile_map_ram_if.slave bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("tile_map_ram: DEPTH exceeds 2**ADDR_WIDTH");
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_num_rd
        $error("tile_map_ram: NUM_RD must be 1..8");
    end

    logic                        busy, done;
    logic                        lw_en;
    logic [ADDR_WIDTH-1:0]       lw_addr;
    logic [DATA_WIDTH-1:0]       lw_data;
    logic                        wr_ack;
    logic                        mem_we;
    logic [ADDR_WIDTH-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    tile_map_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .FILL_VALUE (FILL_VALUE)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (bus.load_start),
        .load_mode  (bus.load_mode),
        .rom_data   (bus.rom_data),
        .rom_addr   (bus.rom_addr),
        .busy       (busy),
        .done       (done),
        .lw_en      (lw_en),
        .lw_addr    (lw_addr),
        .lw_data    (lw_data)
    );

    assign wr_ack = bus.wr_en && !busy && ({1'b0, bus.wr_addr} < DEPTH_C);

    // The loader only writes while busy, and external writes are refused then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (lw_en) begin
            mem_we    = 1'b1;
            mem_waddr = lw_addr;
            mem_wdata = lw_data;
        end else if (wr_ack) begin
            mem_we    = 1'b1;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.wr_data;
        end
    end

    // NOTE: the array has no reset; clearing it is the loader's job.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Reads see the pre-edge array, so a same-cycle write returns old data.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ({1'b0, bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_C)
                rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign bus.rd_data = rd_data_q;
    assign bus.wr_ack  = wr_ack;
    assign bus.busy    = busy;
    assign bus.done    = done;

endmodule

// File: tb/tb_tile_map_ram.sv
// Directed bench for tile_map_ram: clear/copy loads, write gating, read/write
// collision, out-of-range access, reset mid-load and back-to-back starts.
module tb_tile_map_ram;
    import tile_map_pkg::*;

    localparam int DW = 3;
    localparam int AW = 8;
    localparam int NR = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   nbusy;

    tile_map_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

    tile_map_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (192),
        .NUM_RD     (NR),
        .FILL_VALUE (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Level ROM model: image[a] = a % 7, one cycle registered latency.
    always @(posedge clk) bus.rom_data <= DW'(bus.rom_addr % 8'd7);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic mode);
        bus.load_start = 1'b1;
        bus.load_mode  = mode;
        tick();
        bus.load_start = 1'b0;
    endtask

    // Counts busy cycles until FINISH; optionally pokes a write and a stray
    // load_start at busy cycle poke_at.
    task automatic wait_done(input int poke_at, output int n);
        n = 0;
        while (bus.busy && n < 1000) begin
            n++;
            if (n == poke_at) begin
                bus.wr_en      = 1'b1;
                bus.wr_addr    = 8'd5;
                bus.wr_data    = TILE_BRICK;
                bus.load_start = 1'b1;
                bus.load_mode  = LOAD_COPY;
                #1;
                check("wr_ack_during_busy", bus.wr_ack, 0);
            end
            tick();
            bus.wr_en      = 1'b0;
            bus.load_start = 1'b0;
        end
        check("done_at_finish", bus.done, 1);
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_addr    = '0;
        bus.load_start = 1'b0;
        bus.load_mode  = LOAD_CLEAR;
        bus.rom_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        rst = 1'b0;
        tick();

        // Clear with a refused write and a stray load_start mid-load.
        start_load(LOAD_CLEAR);
        check("clr_busy_start", bus.busy, 1);
        wait_done(100, nbusy);
        check("clr_busy_cycles", nbusy, 192);
        // load_start in the FINISH cycle is ignored.
        bus.load_start = 1'b1;
        bus.load_mode  = LOAD_CLEAR;
        tick();
        bus.load_start = 1'b0;
        check("finish_start_ignored", bus.busy, 0);
        check("done_single_pulse", bus.done, 0);
        // One cycle after done a new load starts.
        start_load(LOAD_CLEAR);
        check("restart_busy", bus.busy, 1);
        wait_done(-1, nbusy);
        check("restart_busy_cycles", nbusy, 192);
        tick();

        read2(8'd0, 8'd95);
        check("clr_rd0_addr0", bus.rd_data[2:0], 0);
        check("clr_rd1_addr95", bus.rd_data[5:3], 0);
        read2(8'd191, 8'd5);
        check("clr_rd0_addr191", bus.rd_data[2:0], 0);
        check("dropped_write_addr5", bus.rd_data[5:3], 0);

        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd5;
        bus.wr_data = TILE_BRICK;
        #1;
        check("wr_ack_idle", bus.wr_ack, 1);
        tick();
        bus.wr_en = 1'b0;
        read2(8'd5, 8'd5);
        check("write_rd0_addr5", bus.rd_data[2:0], 1);
        check("write_rd1_addr5", bus.rd_data[5:3], 1);

        // Copy from ROM.
        start_load(LOAD_COPY);
        wait_done(-1, nbusy);
        check("copy_busy_cycles", nbusy, 193);
        check("rom_addr_holds", bus.rom_addr, 191);
        tick();
        read2(8'd0, 8'd0);
        check("copy_addr0", bus.rd_data[2:0], 0);
        bus.rd_addr = {8'd191, 8'd10};
        #1;
        check("read_latency", bus.rd_data[2:0], 0);
        tick();
        check("copy_rd0_addr10", bus.rd_data[2:0], 3);
        check("copy_rd1_addr191", bus.rd_data[5:3], 2);

        // Read/write collision returns old data.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd20;
        bus.wr_data = TILE_STEEL;
        tick();
        bus.wr_data = TILE_TREE;
        bus.rd_addr = {8'd0, 8'd20};
        tick();
        bus.wr_en = 1'b0;
        check("collision_old", bus.rd_data[2:0], 2);
        tick();
        check("collision_new", bus.rd_data[2:0], 4);

        read2(8'd200, 8'd200);
        check("oob_rd0", bus.rd_data[2:0], 0);
        check("oob_rd1", bus.rd_data[5:3], 0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd200;
        #1;
        check("oob_wr_ack", bus.wr_ack, 0);
        bus.wr_en = 1'b0;
        tick();

        // Reset in the middle of a copy over a cleared map.
        start_load(LOAD_CLEAR);
        wait_done(-1, nbusy);
        tick();
        start_load(LOAD_COPY);
        repeat (51) tick();
        check("midload_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        tick();
        rst = 1'b0;
        tick();
        read2(8'd10, 8'd48);
        check("partial_addr10", bus.rd_data[2:0], 3);
        check("partial_addr48", bus.rd_data[5:3], 6);
        read2(8'd50, 8'd190);
        check("untouched_addr50", bus.rd_data[2:0], 0);
        check("untouched_addr190", bus.rd_data[5:3], 0);

        start_load(LOAD_COPY);
        wait_done(-1, nbusy);
        check("reload_busy_cycles", nbusy, 193);
        tick();
        read2(8'd50, 8'd190);
        check("reload_addr50", bus.rd_data[2:0], 1);
        check("reload_addr190", bus.rd_data[5:3], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_map_ram.md
Name: tile_map_ram

Overview:
- Parametrised tile-map store for the battle-tank playfield: one tile code per map cell.
- One synchronous write port for game logic (brick destruction, base damage).
- NUM_RD independent registered read ports for the renderer, tank collision and bullet collision.
- Built-in level loader: clears the map to a fill value, or copies a level image from an external ROM, one cell per clock.

Parameters:
- DATA_WIDTH, 3, bits per tile code.
- ADDR_WIDTH, 8, cell address width; DEPTH <= 2**ADDR_WIDTH required (elaboration error otherwise).
- DEPTH, 192, number of map cells.
- NUM_RD, 2, number of read ports, 1..8.
- FILL_VALUE, 0, tile code written by clear mode.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write cell address.
- wr_data  in  DATA_WIDTH  write tile code.
- wr_ack  out  1  combinational: wr_en && !busy && wr_addr < DEPTH.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed registered read data, same packing.
- load_start  in  1  single-cycle pulse that starts the loader.
- load_mode  in  1  0 = clear to FILL_VALUE, 1 = copy from ROM; sampled with load_start.
- rom_addr  out  ADDR_WIDTH  level ROM address.
- rom_data  in  DATA_WIDTH  level ROM data; ROM has 1-cycle registered latency.
- busy  out  1  loader active.
- done  out  1  one-cycle pulse when the loader finishes.

Behaviour:
- Reset values: rd_data all 0, busy 0, done 0, rom_addr 0, FSM in IDLE. Memory array is not reset.
- Reads:
  - 1-cycle latency: rd_data[i] at edge k+1 = mem[rd_addr[i]] as sampled at edge k.
  - Address >= DEPTH returns 0.
- Writes:
  - mem[wr_addr] <= wr_data at the rising edge when wr_ack = 1.
  - Writes are silently dropped when busy = 1 or when the address is out of range.
- Read/write collision: a read of the address being written in the same cycle returns the OLD value; the new value is visible from the next read.
- Multiple read ports may hit the same address; each returns the same data.
- Reads are allowed during busy and return the partially loaded contents.
- Loader FSM states: IDLE, CLEAR, COPY_PRIME, COPY, FINISH.
  - IDLE: on load_start, go to CLEAR (mode 0) or COPY_PRIME (mode 1). Counter = 0, busy = 1 from the next edge. load_start while not in IDLE is ignored.
  - CLEAR: mem[cnt] <= FILL_VALUE each cycle, cnt increments. At cnt = DEPTH-1, go to FINISH. Exactly DEPTH write cycles.
  - COPY_PRIME: rom_addr = 0, cnt increments to 1, go to COPY.
  - COPY: each cycle, mem[cnt-1] <= rom_data and rom_addr = cnt. The final write, to DEPTH-1, happens in the cycle after rom_addr = DEPTH-1, then go to FINISH. Total DEPTH+1 busy cycles.
  - FINISH: done = 1 for one cycle, busy = 0 in the same cycle, return to IDLE.
- rom_addr holds its last value outside COPY_PRIME/COPY.
- A load_start in the FINISH cycle is ignored; a load_start one cycle later starts a new load.
- Reset mid-load: FSM returns to IDLE immediately, busy and done drop to 0, no done pulse. Cells already loaded keep their new values; the rest keep their old values.
- Counter width is ADDR_WIDTH+1, so DEPTH = 2**ADDR_WIDTH does not wrap early.

Decomposition:
- Package tile_map_pkg holds:
  - tile code constants: TILE_EMPTY = 0, TILE_BRICK = 1, TILE_STEEL = 2, TILE_WATER = 3, TILE_TREE = 4, TILE_BASE = 5, TILE_BASE_DEAD = 6;
  - loader state encoding;
  - LOAD_CLEAR / LOAD_COPY mode constants.
- Sub-module tile_map_loader: FSM, counter, rom_addr, busy/done. It outputs the internal write enable, address and data, which tile_map_ram muxes ahead of the external write port.

Test Plan:
- Clear: mode 0 with FILL_VALUE = 0 -> busy high for exactly 192 cycles, done pulses once. Reading addresses 0, 95 and 191 returns 0.
- Copy: ROM holds mem[a] = a % 7 -> busy high for 193 cycles. Afterwards rd port 0 at addr 10 returns 3 and rd port 1 at addr 191 returns 2, each one cycle after the address is applied.
- Write during busy: wr_en at addr 5 with data 1 mid-clear -> wr_ack = 0 and addr 5 reads 0 after done. The same write after done -> wr_ack = 1 and the read returns 1.
- Collision: write 4 to addr 20, which holds 2, while rd port 0 reads addr 20 in the same cycle -> returns 2; the next read returns 4. rd_addr = 200 -> returns 0.
- Reset mid-load: assert rst at cycle 50 of a copy -> busy = 0 and done = 0 immediately. Cells 0..48 hold ROM data and cells >= 50 hold their previous contents. A subsequent load completes normally.
- Back-to-back: load_start asserted during busy and in the FINISH cycle -> ignored. load_start one cycle after done -> a new load starts.
